// File: rtl/genesis_pad_pkg.sv
// Shared constants for the DB9 Genesis pad blocks: button bit indices, the
// 6-button phase values and the idle level of the data pins.
package genesis_pad_pkg;

  // buttons vector: {Start, C, B, A, Right, Left, Down, Up}
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_START = 7;

  // ext_buttons vector: {Mode, X, Y, Z}
  localparam int unsigned EXT_Z     = 0;
  localparam int unsigned EXT_Y     = 1;
  localparam int unsigned EXT_X     = 2;
  localparam int unsigned EXT_MODE  = 3;

  localparam logic [2:0] PH_ID   = 3'd3;
  localparam logic [2:0] PH_EXT  = 3'd3;
  localparam logic [2:0] PH_DONE = 3'd4;

  // Pin vector layout used throughout: {pin8, pin5, pin3, pin2, pin1, pin0}
  localparam logic [5:0] PINS_RESET = '1;

  function automatic logic [5:0] normal_map(input logic sel, input logic [7:0] btn);
    if (sel)
      return ~{btn[BTN_C], btn[BTN_B], btn[BTN_RIGHT], btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_UP]};
    return {~btn[BTN_START], ~btn[BTN_A], 1'b0, 1'b0, ~btn[BTN_DOWN], ~btn[BTN_UP]};
  endfunction

endpackage

// File: rtl/genesis_pad_responder_select_sync.sv
// Two-flop synchronizer for a console-driven DB9 select line; resets to the
// idle-high level so a released pad looks like select high.
module select_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/genesis_pad_responder.sv
// Genesis pad emulator: drives active-low data pins from select and buttons.
// Define SIX_BUTTON_EN to build the phase counter, idle timer and 6-button decode.
module genesis_pad_responder
  import genesis_pad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       sysclk,
  input  logic       clr,
  input  logic [7:0] buttons,
  input  logic [3:0] ext_buttons,
  input  logic       pin6,
  output logic       pin0,
  output logic       pin1,
  output logic       pin2,
  output logic       pin3,
  output logic       pin5,
  output logic       pin8
);

  logic       w_sel_s;
  logic       r_sel_d;
  logic [7:0] r_btn_q;
  logic [5:0] r_pins;
  logic [5:0] w_pins_next;

  select_sync u_select_sync (
    .i_clk   (sysclk),
    .i_rst   (clr),
    .i_async (pin6),
    .o_sync  (w_sel_s)
  );

  always_ff @(posedge sysclk or posedge clr) begin
    if (clr) begin
      r_sel_d <= 1'b1;
      r_btn_q <= '0;
      r_pins  <= PINS_RESET;
    end else begin
      r_sel_d <= w_sel_s;
      r_btn_q <= buttons;
      r_pins  <= w_pins_next;
    end
  end

  assign {pin8, pin5, pin3, pin2, pin1, pin0} = r_pins;

`ifdef SIX_BUTTON_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    r_ext_q;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          w_edge;
  logic          w_fall;
  logic          w_expired;

  assign w_edge    = r_sel_d ^ w_sel_s;
  assign w_fall    = r_sel_d & ~w_sel_s;
  assign w_expired = (r_timer == TMAX);

  always_comb begin
    // Expiry clears first, then a same-cycle falling edge counts from zero.
    w_cnt_next = w_expired ? '0 : r_cnt;
    if (w_fall && (w_cnt_next != PH_DONE))
      w_cnt_next = w_cnt_next + 3'd1;

    if (w_edge)
      w_timer_next = '0;
    else if (w_expired)
      w_timer_next = r_timer;
    else
      w_timer_next = r_timer + 1'b1;

    w_pins_next = normal_map(w_sel_s, r_btn_q);
    if (!w_sel_s && (w_cnt_next == PH_ID))
      w_pins_next[3:0] = '0;
    else if (w_sel_s && (w_cnt_next == PH_EXT))
      w_pins_next[3:0] = ~{r_ext_q[EXT_MODE], r_ext_q[EXT_X], r_ext_q[EXT_Y], r_ext_q[EXT_Z]};
    else if (!w_sel_s && (w_cnt_next == PH_DONE))
      w_pins_next[3:0] = '1;
  end

  always_ff @(posedge sysclk or posedge clr) begin
    if (clr) begin
      r_ext_q <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_ext_q <= ext_buttons;
      r_cnt   <= w_cnt_next;
      r_timer <= w_timer_next;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^ext_buttons) ^ (TIMEOUT_CYCLES < 4);

  always_comb begin
    w_pins_next = normal_map(w_sel_s, r_btn_q);
  end
`endif

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder; 6-button expectations apply when
// SIX_BUTTON_EN is defined, otherwise every phase must decode as a 3-button pad.
module tb_genesis_pad_responder;

  logic       sysclk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] buttons = '0;
  logic [3:0] ext_buttons = '0;
  logic       pin6 = 1'b1;
  logic       pin0, pin1, pin2, pin3, pin5, pin8;
  logic [5:0] pins;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // {pin8, pin5, pin3, pin2, pin1, pin0}, buttons = Down+Left, ext = Y+Z
  localparam logic [5:0] P_LO_NORM = 6'b110001;
  localparam logic [5:0] P_HI_NORM = 6'b111001;
`ifdef SIX_BUTTON_EN
  localparam logic [5:0] P_LO_ID   = 6'b110000;
  localparam logic [5:0] P_HI_EXT  = 6'b111100;
  localparam logic [5:0] P_LO_DONE = 6'b111111;
`else
  localparam logic [5:0] P_LO_ID   = P_LO_NORM;
  localparam logic [5:0] P_HI_EXT  = P_HI_NORM;
  localparam logic [5:0] P_LO_DONE = P_LO_NORM;
`endif

  genesis_pad_responder #(.TIMEOUT_CYCLES(64)) dut (
    .sysclk      (sysclk),
    .clr         (clr),
    .buttons     (buttons),
    .ext_buttons (ext_buttons),
    .pin6        (pin6),
    .pin0        (pin0),
    .pin1        (pin1),
    .pin2        (pin2),
    .pin3        (pin3),
    .pin5        (pin5),
    .pin8        (pin8)
  );

  always #5 sysclk = ~sysclk;
  assign pins = {pin8, pin5, pin3, pin2, pin1, pin0};

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic half(input logic lvl, input int n);
    pin6 = lvl;
    cycles(n);
  endtask

  task automatic apply_reset();
    clr = 1'b1;
    pin6 = 1'b1;
    buttons = '0;
    ext_buttons = '0;
    cycles(2);
    clr = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    pin6 = 1'b1;
    buttons = 8'hFF;
    cycles(3);
    checks++;
    if (pins !== 6'b111111) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", pins, 6'b111111);
    end
    clr = 1'b0;
    cycles(1);
    checks++;
    if (pins !== 6'b111111) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", pins, 6'b111111);
    end
  endtask

  task automatic test_three_high();
    apply_reset();
    buttons = 8'b0010_0101;
    half(1'b0, 10);
    pin6 = 1'b1;
    cycles(2);
    checks++;
    if (pins !== 6'b110010) begin
      errors++; $display("FAIL high_before got=%b exp=%b", pins, 6'b110010);
    end
    cycles(1);
    checks++;
    if (pins !== 6'b101010) begin
      errors++; $display("FAIL high_map got=%b exp=%b", pins, 6'b101010);
    end
  endtask

  task automatic test_three_low();
    apply_reset();
    buttons = 8'b1001_0000;
    cycles(5);
    pin6 = 1'b0;
    cycles(2);
    checks++;
    if (pins !== 6'b111111) begin
      errors++; $display("FAIL low_before got=%b exp=%b", pins, 6'b111111);
    end
    cycles(1);
    checks++;
    if (pins !== 6'b000011) begin
      errors++; $display("FAIL low_map got=%b exp=%b", pins, 6'b000011);
    end
  endtask

  task automatic test_button_latency();
    apply_reset();
    buttons = 8'b0000_0011;
    cycles(1);
    checks++;
    if (pins !== 6'b111111) begin
      errors++; $display("FAIL btn_lat1 got=%b exp=%b", pins, 6'b111111);
    end
    cycles(1);
    checks++;
    if (pins !== 6'b111100) begin
      errors++; $display("FAIL btn_lat2 got=%b exp=%b", pins, 6'b111100);
    end
  endtask

  task automatic test_six_sequence();
    logic [5:0] exp_lo [4];
    logic [5:0] exp_hi [4];
    exp_lo = '{P_LO_NORM, P_LO_NORM, P_LO_ID, P_LO_DONE};
    exp_hi = '{P_HI_NORM, P_HI_NORM, P_HI_EXT, P_HI_NORM};
    apply_reset();
    buttons = 8'b0000_0110;
    ext_buttons = 4'b0011;
    cycles(5);
    for (int p = 0; p < 4; p++) begin
      half(1'b0, 10);
      checks++;
      if (pins !== exp_lo[p]) begin
        errors++; $display("FAIL seq_low%0d got=%b exp=%b", p + 1, pins, exp_lo[p]);
      end
      half(1'b1, 10);
      checks++;
      if (pins !== exp_hi[p]) begin
        errors++; $display("FAIL seq_high%0d got=%b exp=%b", p + 1, pins, exp_hi[p]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    buttons = 8'b0000_0110;
    ext_buttons = 4'b0011;
    half(1'b0, 10); half(1'b1, 10);
    half(1'b0, 10); half(1'b1, 100);
    half(1'b0, 10);
    checks++;
    if (pins !== P_LO_NORM) begin
      errors++; $display("FAIL tmo_low1 got=%b exp=%b", pins, P_LO_NORM);
    end
    half(1'b1, 10);
    checks++;
    if (pins !== P_HI_NORM) begin
      errors++; $display("FAIL tmo_high1 got=%b exp=%b", pins, P_HI_NORM);
    end
    half(1'b0, 10); half(1'b1, 10);
    half(1'b0, 10);
    checks++;
    if (pins !== P_LO_ID) begin
      errors++; $display("FAIL tmo_low3 got=%b exp=%b", pins, P_LO_ID);
    end
  endtask

  // The fall is detected in exactly the cycle the idle timer first reads 63.
  task automatic test_timeout_coincident();
    apply_reset();
    buttons = 8'b0000_0110;
    ext_buttons = 4'b0011;
    half(1'b0, 10); half(1'b1, 10);
    half(1'b0, 10); half(1'b1, 64);
    half(1'b0, 10);
    checks++;
    if (pins !== P_LO_NORM) begin
      errors++; $display("FAIL coin_low1 got=%b exp=%b", pins, P_LO_NORM);
    end
    half(1'b1, 10);
    half(1'b0, 10);
    checks++;
    if (pins !== P_LO_NORM) begin
      errors++; $display("FAIL coin_low2 got=%b exp=%b", pins, P_LO_NORM);
    end
    half(1'b1, 10);
    half(1'b0, 10);
    checks++;
    if (pins !== P_LO_ID) begin
      errors++; $display("FAIL coin_low3 got=%b exp=%b", pins, P_LO_ID);
    end
  endtask

  task automatic test_reset_midsequence();
    apply_reset();
    buttons = 8'b0000_0110;
    ext_buttons = 4'b0011;
    half(1'b0, 10); half(1'b1, 10);
    half(1'b0, 10); half(1'b1, 10);
    half(1'b0, 10);
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if (pins !== 6'b111111) begin
      errors++; $display("FAIL mid_reset_async got=%b exp=%b", pins, 6'b111111);
    end
    cycles(2);
    clr = 1'b0;
    cycles(5);
    checks++;
    if (pins !== P_LO_NORM) begin
      errors++; $display("FAIL mid_reset_after got=%b exp=%b", pins, P_LO_NORM);
    end
  endtask

  initial begin
    test_reset();
    test_three_high();
    test_three_low();
    test_button_latency();
    test_six_sequence();
    test_timeout();
    test_timeout_coincident();
    test_reset_midsequence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
